// File: rtl/alien_fleet_controller.sv
`default_nettype none
// ============================================================================
//  Module   : alien_fleet_controller
//  Purpose  : Marches an alien formation left/right across the playfield,
//             descends one row at each side wall, tracks which aliens are
//             still alive and flags "fleet cleared" / "fleet landed".
//  Ports    : pixel_clk        - the only clock
//             rst_n            - synchronous active-low reset
//             fsync            - one-cycle start-of-frame pulse
//             game_state[1:0]  - game phase, 2'd2 = play
//             round[4:0]       - level number, speeds up the march
//             alien_rst        - level-sensitive formation reset request
//             hit_valid        - one-cycle bullet hit strobe
//             hit_index[3:0]   - alien that was hit
//             alive_mask       - one alive bit per alien
//             aliens_remaining - count of set bits in alive_mask
//             fleet_x/fleet_y  - formation origin in pixels
//             all_aliens_dead  - sticky until alien_rst
//             aliens_landed    - sticky until alien_rst
//  Option   : define FLEET_SHRINK_SPEEDUP_EN to shorten the step period by
//             one frame (minimum 1) while four or fewer aliens remain.
//  Revision : 1.0 - initial release
// ============================================================================
module alien_fleet_controller #(
  parameter int NUM_ALIENS  = 16,
  parameter int X_MIN       = 16,
  parameter int X_MAX       = 400,
  parameter int STEP_X      = 8,
  parameter int STEP_Y      = 16,
  parameter int Y_TOP       = 32,
  parameter int Y_BOTTOM    = 400,
  parameter int BASE_PERIOD = 8
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic                  fsync,
  input  logic [1:0]            game_state,
  input  logic [4:0]            round,
  input  logic                  alien_rst,
  input  logic                  hit_valid,
  input  logic [3:0]            hit_index,
  output logic [NUM_ALIENS-1:0] alive_mask,
  output logic [4:0]            aliens_remaining,
  output logic [9:0]            fleet_x,
  output logic [9:0]            fleet_y,
  output logic                  all_aliens_dead,
  output logic                  aliens_landed
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARCH   = 2'd1,
    ST_CLEARED = 2'd2,
    ST_LANDED  = 2'd3
  } state_t;

  // Position arithmetic is done one bit wider so wall checks cannot wrap.
  localparam logic [10:0] c_X_MIN    = 11'(X_MIN);
  localparam logic [10:0] c_X_MAX    = 11'(X_MAX);
  localparam logic [10:0] c_STEP_X   = 11'(STEP_X);
  localparam logic [10:0] c_STEP_Y   = 11'(STEP_Y);
  localparam logic [10:0] c_Y_BOTTOM = 11'(Y_BOTTOM);
  localparam logic [9:0]  c_X_START  = 10'(X_MIN);
  localparam logic [9:0]  c_Y_START  = 10'(Y_TOP);
  localparam logic [4:0]  c_NUM      = 5'(NUM_ALIENS);
  localparam logic [7:0]  c_BASE     = 8'(BASE_PERIOD);
  localparam logic [1:0]  c_PLAY     = 2'd2;

  state_t                r_state,  w_state_nxt;
  logic [NUM_ALIENS-1:0] r_mask,   w_mask_nxt;
  logic [4:0]            r_rem,    w_rem_nxt;
  logic [9:0]            r_x,      w_x_nxt;
  logic [9:0]            r_y,      w_y_nxt;
  logic                  r_dir,    w_dir_nxt;     // 1 = moving right
  logic [7:0]            r_cnt,    w_cnt_nxt;
  logic                  r_dead,   w_dead_nxt;
  logic                  r_landed, w_landed_nxt;

  logic [7:0]  w_period_base;
  logic [7:0]  w_period;
  logic [10:0] w_x_right;
  logic [10:0] w_x_left;
  logic [10:0] w_y_down;
  logic        w_hit_ok;
  logic        w_kill_all;
  logic        w_land;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mask   <= '1;
      r_rem    <= c_NUM;
      r_x      <= c_X_START;
      r_y      <= c_Y_START;
      r_dir    <= 1'b1;
      r_cnt    <= 8'd0;
      r_dead   <= 1'b0;
      r_landed <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mask   <= w_mask_nxt;
      r_rem    <= w_rem_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_dir    <= w_dir_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dead   <= w_dead_nxt;
      r_landed <= w_landed_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mask_nxt   = r_mask;
    w_rem_nxt    = r_rem;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_dir_nxt    = r_dir;
    w_cnt_nxt    = r_cnt;
    w_dead_nxt   = r_dead;
    w_landed_nxt = r_landed;
    w_kill_all   = 1'b0;
    w_land       = 1'b0;

    // Frames per step: BASE_PERIOD - round, never below one.
    if ({3'b000, round} >= c_BASE) begin
      w_period_base = 8'd1;
    end else begin
      w_period_base = c_BASE - {3'b000, round};
    end
    w_period = w_period_base;
`ifdef FLEET_SHRINK_SPEEDUP_EN
    if ((r_rem <= 5'd4) && (w_period_base > 8'd1)) begin
      w_period = w_period_base - 8'd1;
    end
`endif

    w_x_right = {1'b0, r_x} + c_STEP_X;
    w_x_left  = {1'b0, r_x} - c_STEP_X;
    w_y_down  = {1'b0, r_y} + c_STEP_Y;
    w_hit_ok  = hit_valid && (int'({1'b0, hit_index}) < NUM_ALIENS) && r_mask[hit_index];

    if (alien_rst) begin
      w_state_nxt  = ST_IDLE;
      w_mask_nxt   = '1;
      w_rem_nxt    = c_NUM;
      w_x_nxt      = c_X_START;
      w_y_nxt      = c_Y_START;
      w_dir_nxt    = 1'b1;
      w_cnt_nxt    = 8'd0;
      w_dead_nxt   = 1'b0;
      w_landed_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (game_state == c_PLAY) begin
            w_state_nxt = ST_MARCH;
          end
        end
        ST_MARCH: begin
          if ((game_state == c_PLAY) && fsync) begin
            // ">=" also catches a counter left above a freshly shortened period.
            if (r_cnt >= (w_period - 8'd1)) begin
              w_cnt_nxt = 8'd0;
              if (r_dir && (w_x_right <= c_X_MAX)) begin
                w_x_nxt = w_x_right[9:0];
              end else if (!r_dir && ({1'b0, r_x} >= (c_X_MIN + c_STEP_X))) begin
                w_x_nxt = w_x_left[9:0];
              end else begin
                w_y_nxt   = w_y_down[9:0];
                w_dir_nxt = ~r_dir;
                w_land    = (w_y_down >= c_Y_BOTTOM);
              end
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end
          // Hits are taken even while paused, and alongside a step.
          if (w_hit_ok) begin
            w_mask_nxt[hit_index] = 1'b0;
            w_rem_nxt             = r_rem - 5'd1;
            w_kill_all            = (r_rem == 5'd1);
          end
          // A last kill on the landing cycle counts as a clear.
          if (w_kill_all) begin
            w_state_nxt = ST_CLEARED;
            w_dead_nxt  = 1'b1;
          end else if (w_land) begin
            w_state_nxt  = ST_LANDED;
            w_landed_nxt = 1'b1;
          end
        end
        default: begin
          // CLEARED / LANDED: everything frozen until alien_rst.
        end
      endcase
    end
  end

  assign alive_mask       = r_mask;
  assign aliens_remaining = r_rem;
  assign fleet_x          = r_x;
  assign fleet_y          = r_y;
  assign all_aliens_dead  = r_dead;
  assign aliens_landed    = r_landed;

endmodule
`default_nettype wire

// File: tb/tb_alien_fleet_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alien_fleet_controller
//  Purpose  : Self-checking bench for alien_fleet_controller. A behavioural
//             model (fsync counting, integer position, mask population
//             count) is advanced every clock and compared with the DUT,
//             alongside directed checks of the documented scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alien_fleet_controller;

  localparam int M_IDLE = 0, M_MARCH = 1, M_CLEARED = 2, M_LANDED = 3;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic        fsync;
  logic [1:0]  game_state;
  logic [4:0]  round;
  logic        alien_rst;
  logic        hit_valid;
  logic [3:0]  hit_index;
  logic [15:0] alive_mask;
  logic [4:0]  aliens_remaining;
  logic [9:0]  fleet_x;
  logic [9:0]  fleet_y;
  logic        all_aliens_dead;
  logic        aliens_landed;

  int          n_assert = 0;
  int          n_fail   = 0;
  string       g_tag    = "init";

  // Behavioural model
  int          m_mode, m_x, m_y, m_dir, m_cnt;
  logic [15:0] m_mask;

  alien_fleet_controller dut (
    .pixel_clk        (pixel_clk),
    .rst_n            (rst_n),
    .fsync            (fsync),
    .game_state       (game_state),
    .round            (round),
    .alien_rst        (alien_rst),
    .hit_valid        (hit_valid),
    .hit_index        (hit_index),
    .alive_mask       (alive_mask),
    .aliens_remaining (aliens_remaining),
    .fleet_x          (fleet_x),
    .fleet_y          (fleet_y),
    .all_aliens_dead  (all_aliens_dead),
    .aliens_landed    (aliens_landed)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int period_of();
    int p;
    p = 8 - int'(round);
    if (p < 1) p = 1;
`ifdef FLEET_SHRINK_SPEEDUP_EN
    if ($countones(m_mask) <= 4 && p > 1) p = p - 1;
`endif
    return p;
  endfunction

  task automatic model_tick();
    int  nx;
    bit  landed;
    landed = 0;
    if (!rst_n || alien_rst) begin
      m_mode = M_IDLE; m_x = 16; m_y = 32; m_dir = 1; m_cnt = 0; m_mask = 16'hFFFF;
    end else if (m_mode == M_IDLE) begin
      if (game_state == 2'd2) m_mode = M_MARCH;
    end else if (m_mode == M_MARCH) begin
      if (game_state == 2'd2 && fsync) begin
        m_cnt++;
        if (m_cnt >= period_of()) begin
          m_cnt = 0;
          nx = m_x + 8 * m_dir;
          if (nx >= 16 && nx <= 400) m_x = nx;
          else begin
            m_y   = m_y + 16;
            m_dir = -m_dir;
            if (m_y >= 400) landed = 1;
          end
        end
      end
      if (hit_valid && m_mask[hit_index]) m_mask[hit_index] = 1'b0;
      if ($countones(m_mask) == 0) m_mode = M_CLEARED;
      else if (landed) m_mode = M_LANDED;
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    model_tick();
    #1;
    chk({g_tag, ":mask"},   alive_mask,       m_mask);
    chk({g_tag, ":remain"}, aliens_remaining, $countones(m_mask));
    chk({g_tag, ":x"},      fleet_x,          m_x);
    chk({g_tag, ":y"},      fleet_y,          m_y);
    chk({g_tag, ":dead"},   all_aliens_dead,  m_mode == M_CLEARED);
    chk({g_tag, ":landed"}, aliens_landed,    m_mode == M_LANDED);
  endtask

  task automatic pulse();
    fsync = 1'b1; tick();
    fsync = 1'b0; tick();
  endtask

  task automatic hit(input int idx);
    hit_valid = 1'b1; hit_index = 4'(idx); tick();
    hit_valid = 1'b0;
  endtask

  task automatic formation_reset();
    alien_rst = 1'b1; tick();
    alien_rst = 1'b0;
  endtask

  function automatic bit descend_next();
    return (m_dir > 0) ? (m_x + 8 > 400) : (m_x - 8 < 16);
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; fsync = 1'b0; game_state = 2'd0; round = 5'd0;
    alien_rst = 1'b0; hit_valid = 1'b0; hit_index = 4'd0;

    g_tag = "reset";
    tick(); tick();
    chk("rst_x", fleet_x, 16);
    chk("rst_y", fleet_y, 32);
    chk("rst_mask", alive_mask, 16'hFFFF);
    chk("rst_remain", aliens_remaining, 16);
    rst_n = 1'b1;

    // Step timing at round 1: seven frames per step.
    g_tag = "timing";
    formation_reset();
    game_state = 2'd2; round = 5'd1; tick();
    repeat (6) pulse();
    chk("step_after_6", fleet_x, 16);
    fsync = 1'b1; tick();
    chk("step_after_7", fleet_x, 24);
    fsync = 1'b0; tick();

    // Hits.
    g_tag = "hits";
    hit(3);
    chk("hit3_bit", alive_mask[3], 0);
    chk("hit3_remain", aliens_remaining, 15);
    hit(3);
    chk("rehit3_remain", aliens_remaining, 15);
    repeat (6) pulse();
    fsync = 1'b1; hit_valid = 1'b1; hit_index = 4'd15; tick();
    chk("hit_step_x", fleet_x, 32);
    chk("hit_step_remain", aliens_remaining, 14);
    fsync = 1'b0; hit_valid = 1'b0; tick();

    // Pause: no movement, hits still accepted.
    g_tag = "pause";
    game_state = 2'd0;
    repeat (5) pulse();
    chk("pause_x", fleet_x, 32);
    hit(0);
    chk("pause_hit_remain", aliens_remaining, 13);
    game_state = 2'd2;

    // Edge descent at the right wall.
    g_tag = "edge";
    round = 5'd8;
    n = 0;
    while (m_x != 400 && n < 100) begin pulse(); n++; end
    chk("edge_reach_x", fleet_x, 400);
    pulse();
    chk("edge_desc_x", fleet_x, 400);
    chk("edge_desc_y", fleet_y, 48);
    pulse();
    chk("edge_left_x", fleet_x, 392);

    // Randomized traffic against the model.
    g_tag = "random";
    formation_reset();
    for (int i = 0; i < 800; i++) begin
      game_state = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      round      = 5'($urandom_range(0, 10));
      fsync      = ($urandom_range(0, 2) == 0);
      hit_valid  = ($urandom_range(0, 5) == 0);
      hit_index  = 4'($urandom_range(0, 15));
      alien_rst  = ($urandom_range(0, 199) == 0);
      rst_n      = ($urandom_range(0, 299) != 0);
      tick();
    end
    fsync = 1'b0; hit_valid = 1'b0; alien_rst = 1'b0; rst_n = 1'b1;

    // Step period with four aliens left at round 0.
    g_tag = "shrink";
    formation_reset();
    game_state = 2'd2; round = 5'd0; tick();
    for (int i = 0; i < 12; i++) hit(i);
    chk("shrink_remain", aliens_remaining, 4);
    n = 0;
    while (fleet_x == 10'd16 && n < 20) begin pulse(); n++; end
`ifdef FLEET_SHRINK_SPEEDUP_EN
    chk("shrink_period", n, 7);
`else
    chk("shrink_period", n, 8);
`endif

    // Landing.
    g_tag = "land";
    formation_reset();
    game_state = 2'd2; round = 5'd31; tick();
    n = 0;
    while (m_mode != M_LANDED && n < 3000) begin pulse(); n++; end
    chk("land_flag", aliens_landed, 1);
    chk("land_y_bottom", fleet_y >= 10'd400, 1);
    chk("land_dead", all_aliens_dead, 0);
    repeat (3) pulse();
    hit(5);
    chk("land_hit_ignored", aliens_remaining, 16);

    // Fleet cleared.
    g_tag = "clear";
    formation_reset();
    tick();
    for (int i = 0; i < 16; i++) hit(i);
    chk("clear_flag", all_aliens_dead, 1);
    chk("clear_remain", aliens_remaining, 0);
    repeat (3) pulse();
    chk("clear_frozen_x", fleet_x, 16);
    formation_reset();
    chk("clear_rst_mask", alive_mask, 16'hFFFF);
    chk("clear_rst_flag", all_aliens_dead, 0);

    // Last kill on the landing step: clear wins.
    g_tag = "tie";
    game_state = 2'd2; round = 5'd31; tick();
    for (int i = 0; i < 15; i++) hit(i);
    n = 0;
    while (!(m_y == 384 && descend_next()) && n < 3000) begin pulse(); n++; end
    fsync = 1'b1; hit_valid = 1'b1; hit_index = 4'd15; tick();
    chk("tie_dead", all_aliens_dead, 1);
    chk("tie_landed", aliens_landed, 0);
    fsync = 1'b0; hit_valid = 1'b0; tick();

    // rst_n mid-march beats everything else.
    g_tag = "midrst";
    formation_reset();
    tick();
    repeat (5) pulse();
    rst_n = 1'b0; fsync = 1'b1; alien_rst = 1'b1; hit_valid = 1'b1; hit_index = 4'd2;
    tick();
    chk("midrst_x", fleet_x, 16);
    chk("midrst_y", fleet_y, 32);
    chk("midrst_remain", aliens_remaining, 16);
    rst_n = 1'b1; fsync = 1'b0; alien_rst = 1'b0; hit_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alien_fleet_controller.md
ALIEN_FLEET_CONTROLLER -- requirements
Module: alien_fleet_controller

Interface
REQ-001 The block SHALL have parameter NUM_ALIENS, default 16, giving the alien count, one alive bit per alien.
REQ-002 The block SHALL have parameter X_MIN, default 16, giving the minimum fleet left-edge pixel.
REQ-003 The block SHALL have parameter X_MAX, default 400, giving the maximum fleet left-edge pixel.
REQ-004 The block SHALL have parameter STEP_X, default 8, giving the horizontal pixels per march step.
REQ-005 The block SHALL have parameters STEP_Y, default 16, giving the vertical pixels per descent; Y_TOP, default 32, giving the start row; and Y_BOTTOM, default 400, giving the landing row.
REQ-006 The block SHALL have parameter BASE_PERIOD, default 8, giving the frames per step at round 0.
REQ-007 Port pixel_clk, input, 1 bit: the only clock.
REQ-008 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 Port fsync, input, 1 bit: one-cycle start-of-frame pulse.
REQ-010 Port game_state, input, 2 bits: game phase; 2'd2 means PLAY_GAME.
REQ-011 Port round, input, 5 bits: current level number.
REQ-012 Port alien_rst, input, 1 bit: level-sensitive formation reset request.
REQ-013 Port hit_valid, input, 1 bit, and port hit_index, input, 4 bits: a one-cycle bullet-hit event on alien hit_index.
REQ-014 Port alive_mask, output, NUM_ALIENS bits; port aliens_remaining, output, 5 bits.
REQ-015 Port fleet_x, output, 10 bits, and port fleet_y, output, 10 bits: the formation origin.
REQ-016 Port all_aliens_dead, output, 1 bit, and port aliens_landed, output, 1 bit: the status flags.

Function
REQ-017 All outputs SHALL be registered, and every output SHALL reflect an input event on the cycle after that event.
REQ-018 States SHALL be IDLE, MARCH, CLEARED and LANDED.
REQ-019 Whenever alien_rst=1, the block SHALL go to IDLE with alive_mask all ones, aliens_remaining=NUM_ALIENS, fleet_x=X_MIN, fleet_y=Y_TOP, direction=right, frame counter 0 and both flags 0, and alien_rst SHALL override every other input on that cycle.
REQ-020 IDLE SHALL go to MARCH when alien_rst=0 and game_state=2'd2.
REQ-021 In MARCH, when game_state is not 2'd2, the frame counter and position SHALL freeze while hits are still accepted.
REQ-022 Step period SHALL be BASE_PERIOD minus round, saturating at a minimum of 1.
REQ-023 In MARCH with game_state=2'd2, each fsync SHALL increment the frame counter; when the counter reaches period-1, the counter SHALL clear and one step SHALL occur.
REQ-024 Step: if fleet_x +/- STEP_X stays within [X_MIN, X_MAX], fleet_x SHALL move by STEP_X in the current direction; otherwise fleet_x SHALL hold, fleet_y SHALL add STEP_Y and direction SHALL invert.
REQ-025 In MARCH, a hit on a set bit SHALL clear that bit and decrement aliens_remaining by 1.
REQ-026 Hits on an already-clear bit, on hit_index>=NUM_ALIENS, or in any state other than MARCH SHALL be ignored.
REQ-027 When a hit and a step occur on the same cycle, both SHALL be applied.
REQ-028 When aliens_remaining reaches 0, the block SHALL go to CLEARED and set all_aliens_dead=1, held until alien_rst.
REQ-029 When a descent makes fleet_y>=Y_BOTTOM, the block SHALL go to LANDED and set aliens_landed=1, held until alien_rst.
REQ-030 When the last kill and a landing occur on the same cycle, CLEARED SHALL win and aliens_landed SHALL stay 0.
REQ-031 In CLEARED and LANDED, position, mask and counter SHALL freeze.

Reset
REQ-032 When rst_n=0 at a pixel_clk edge, the block SHALL take the REQ-019 values and state IDLE, including when reset occurs mid-step or mid-descent.
REQ-033 rst_n SHALL take priority over alien_rst.

Configuration
REQ-034 With macro FLEET_SHRINK_SPEEDUP_EN defined, the step period SHALL be reduced by a further 1 (minimum 1) while aliens_remaining<=4.
REQ-035 With FLEET_SHRINK_SPEEDUP_EN undefined, the step period SHALL depend on round only.

Verification
REQ-036 Scenario, step timing: alien_rst pulse, game_state=2, round=1, 7 fsyncs -> fleet_x 16->24 one cycle after the 7th fsync, and unchanged after the 6th.
REQ-037 Scenario, edge descent: fleet_x=400 moving right, step -> fleet_x=400, fleet_y 32->48, direction left; next step -> fleet_x=392.
REQ-038 Scenario, hit handling: hit index 3 -> alive_mask bit 3=0, aliens_remaining=15; repeat index 3 -> no change; hit_index 15 coincident with a step -> both take effect.
REQ-039 Scenario, fleet cleared: kill all 16 -> all_aliens_dead=1 one cycle after the last hit; further fsyncs leave fleet_x frozen; alien_rst -> mask 16'hFFFF, flag 0.
REQ-040 Scenario, landing and pause: drive descents to fleet_y>=400 -> aliens_landed=1 and state LANDED; game_state=0 during MARCH -> no movement.
REQ-041 Scenario, configuration: with FLEET_SHRINK_SPEEDUP_EN defined, round=0 and 4 aliens left -> step every 7 frames; with it undefined -> step every 8 frames.
